// File: rtl/pueo_filter_pkg.sv
// Shared types and arithmetic helpers for the PUEO SSR FIR datapath.
package pueo_filter_pkg;

  localparam int COEF_BITS = 4;
  typedef logic signed [COEF_BITS-1:0] coef_t;

  function automatic int acc_width(input int nbits, input int cbits, input int ntaps);
    return nbits + cbits + $clog2(ntaps);
  endfunction

  // Clamp a wide signed value into a signed field of obits bits; hit reports a clamp.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int obits,
                                                  output logic hit);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (obits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (obits - 1));
    saturate = v;
    hit = 1'b0;
    if (v > hi) begin
      saturate = hi;
      hit = 1'b1;
    end else if (v < lo) begin
      saturate = lo;
      hit = 1'b1;
    end
  endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Pipelined signed adder tree: pairs are summed level by level with one register per
// level; an odd leftover passes through so every path has the same depth.
module fir_adder_tree #(
  parameter int N      = 42,
  parameter int W      = 22,
  parameter int LEVELS = $clog2(N)
) (
  input  logic         aclk,
  input  logic         rst,
  input  logic [N*W-1:0] sum_in,
  input  logic         valid_in,
  output logic [W-1:0] sum_out,
  output logic         valid_out
);

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int CNT = (N + (1 << l) - 1) >> l;
    logic v;

    if (l == 0) begin : g_v0
      assign v = valid_in;
    end else begin : g_vn
      always_ff @(posedge aclk or posedge rst)
        if (rst) v <= 1'b0;
        else     v <= g_lvl[l-1].v;
    end

    for (genvar j = 0; j < CNT; j++) begin : g_node
      logic signed [W-1:0] s;
      if (l == 0) begin : g_leaf
        assign s = sum_in[j*W +: W];
      end else begin : g_sum
        localparam int PCNT = (N + (1 << (l - 1)) - 1) >> (l - 1);
        if (2*j + 1 < PCNT) begin : g_pair
          always_ff @(posedge aclk or posedge rst)
            if (rst) s <= '0;
            else     s <= g_lvl[l-1].g_node[2*j].s + g_lvl[l-1].g_node[2*j+1].s;
        end else begin : g_pass
          always_ff @(posedge aclk or posedge rst)
            if (rst) s <= '0;
            else     s <= g_lvl[l-1].g_node[2*j].s;
        end
      end
    end
  end

  assign sum_out   = g_lvl[LEVELS].g_node[0].s;
  assign valid_out = g_lvl[LEVELS].v;

endmodule

// File: rtl/ssr_prog_fir.sv
// Programmable super-sample-rate FIR: NSAMPS lanes per clock, runtime coefficients with an
// atomic shadow->active bank swap, valid-qualified pipeline and per-lane shift/saturate.
module ssr_prog_fir
  import pueo_filter_pkg::*;
#(
  parameter int NBITS   = 12,
  parameter int NSAMPS  = 8,
  parameter int NTAPS   = 42,
  parameter int CBITS   = 4,
  parameter int OUTBITS = 16,
  parameter int SHIFT   = 0
) (
  input  logic                      aclk,
  input  logic                      rst,
  input  logic [NBITS*NSAMPS-1:0]   data_i,
  input  logic                      valid_i,
  input  logic                      coef_wr,
  input  logic [$clog2(NTAPS)-1:0]  coef_addr,
  input  logic [CBITS-1:0]          coef_dat,
  input  logic                      coef_commit,
  output logic [OUTBITS*NSAMPS-1:0] data_o,
  output logic                      valid_o,
  output logic [NSAMPS-1:0]         sat_o
);

  localparam int ACCBITS = acc_width(NBITS, CBITS, NTAPS);
  localparam int AW      = $clog2(NTAPS);
  localparam int LATENCY = $clog2(NTAPS) + 2;
  localparam int NPAST   = NTAPS - 1;
  localparam int NWIN    = NSAMPS + NPAST;

  logic signed [CBITS-1:0]   shadow [NTAPS];
  logic signed [CBITS-1:0]   active [NTAPS];
  logic [NPAST*NBITS-1:0]    past;
  logic [NWIN*NBITS-1:0]     win;
  logic signed [ACCBITS-1:0] prod_q [NSAMPS][NTAPS];
  logic                      v1;
  logic [NTAPS*ACCBITS-1:0]  tree_in [NSAMPS];
  logic [ACCBITS-1:0]        tree_sum [NSAMPS];
  logic [NSAMPS-1:0]         tree_v;
  logic [OUTBITS*NSAMPS-1:0] out_d;
  logic [NSAMPS-1:0]         sat_d;

  // A write landing in the commit cycle goes straight into the new active bank too.
  always_ff @(posedge aclk or posedge rst)
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        if (coef_wr && coef_addr == AW'(k)) begin
          shadow[k] <= coef_dat;
          if (coef_commit) active[k] <= coef_dat;
        end else if (coef_commit) begin
          active[k] <= shadow[k];
        end
      end
    end

  // Only the NTAPS-1 most recent samples are ever reached by a tap, so that is all we keep.
  assign win = {data_i, past};

  always_ff @(posedge aclk or posedge rst)
    if (rst) begin
      past <= '0;
      v1   <= 1'b0;
      for (int i = 0; i < NSAMPS; i++)
        for (int k = 0; k < NTAPS; k++)
          prod_q[i][k] <= '0;
    end else begin
      v1 <= valid_i;
      if (valid_i) begin
        past <= win[NWIN*NBITS-1 -: NPAST*NBITS];
        for (int i = 0; i < NSAMPS; i++)
          for (int k = 0; k < NTAPS; k++)
            prod_q[i][k] <= ACCBITS'($signed(win[(NPAST + i - k)*NBITS +: NBITS]))
                            * ACCBITS'(active[k]);
      end
    end

  always_comb begin
    for (int i = 0; i < NSAMPS; i++) begin
      tree_in[i] = '0;
      for (int k = 0; k < NTAPS; k++)
        tree_in[i][k*ACCBITS +: ACCBITS] = prod_q[i][k];
    end
  end

  for (genvar i = 0; i < NSAMPS; i++) begin : g_lane
    fir_adder_tree #(
      .N      (NTAPS),
      .W      (ACCBITS),
      .LEVELS (LATENCY - 2)
    ) u_tree (
      .aclk      (aclk),
      .rst       (rst),
      .sum_in    (tree_in[i]),
      .valid_in  (v1),
      .sum_out   (tree_sum[i]),
      .valid_out (tree_v[i])
    );
  end

  always_comb begin
    logic signed [63:0] wide;
    logic signed [63:0] clip;
    logic               hit;
    out_d = '0;
    sat_d = '0;
    wide  = '0;
    clip  = '0;
    hit   = 1'b0;
    for (int i = 0; i < NSAMPS; i++) begin
      wide = 64'($signed(tree_sum[i])) >>> SHIFT;
      clip = saturate(wide, OUTBITS, hit);
      out_d[i*OUTBITS +: OUTBITS] = OUTBITS'(clip);
      sat_d[i] = hit;
    end
  end

  always_ff @(posedge aclk or posedge rst)
    if (rst) begin
      data_o  <= '0;
      sat_o   <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= &tree_v;
      if (&tree_v) begin
        data_o <= out_d;
        sat_o  <= sat_d;
      end
    end

endmodule

// File: tb/tb_ssr_prog_fir.sv
// Bench for ssr_prog_fir: random stimulus against a flattened-stream convolution model.
module tb_ssr_prog_fir;
  import pueo_filter_pkg::*;

  localparam int NBITS   = 12;
  localparam int NSAMPS  = 8;
  localparam int NTAPS   = 42;
  localparam int CBITS   = 4;
  localparam int OUTBITS = 16;
  localparam int SHIFT   = 0;
  localparam int AW      = $clog2(NTAPS);
  localparam int LATENCY = $clog2(NTAPS) + 2;
  localparam int OMAX    = (1 << (OUTBITS - 1)) - 1;
  localparam int OMIN    = -(1 << (OUTBITS - 1));

  logic                      aclk;
  logic                      rst;
  logic [NBITS*NSAMPS-1:0]   data_i;
  logic                      valid_i;
  logic                      coef_wr;
  logic [AW-1:0]             coef_addr;
  logic [CBITS-1:0]          coef_dat;
  logic                      coef_commit;
  logic [OUTBITS*NSAMPS-1:0] data_o;
  logic                      valid_o;
  logic [NSAMPS-1:0]         sat_o;

  ssr_prog_fir #(
    .NBITS(NBITS), .NSAMPS(NSAMPS), .NTAPS(NTAPS),
    .CBITS(CBITS), .OUTBITS(OUTBITS), .SHIFT(SHIFT)
  ) dut (
    .aclk        (aclk),
    .rst         (rst),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .coef_wr     (coef_wr),
    .coef_addr   (coef_addr),
    .coef_dat    (coef_dat),
    .coef_commit (coef_commit),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .sat_o       (sat_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic                      v;
    logic [OUTBITS*NSAMPS-1:0] d;
    logic [NSAMPS-1:0]         s;
  } beat_t;

  int nchk = 0;
  int nerr = 0;

  // Reference state: every valid sample since reset, coefficient banks, output delay line.
  int    xs[$];
  int    sh_m [NTAPS];
  int    act_m [NTAPS];
  beat_t dl [LATENCY];
  int    din [NSAMPS];
  logic                      exp_valid;
  logic [OUTBITS*NSAMPS-1:0] exp_data;
  logic [NSAMPS-1:0]         exp_sat;

  int h_golden [NTAPS] = '{-1,-1,0,0,0,1,1,0, 0,-1,-1,-1,0,1,1,1,
                           1,0,-1,-1,-1,0,1,2, 1,0,-1,-2,-2,0,2,4,
                           0,-4,-4,1,4,1,-2,-1, 1,1};

  function automatic void model_reset();
    xs.delete();
    for (int k = 0; k < NTAPS; k++) begin
      sh_m[k] = 0;
      act_m[k] = 0;
    end
    for (int j = 0; j < LATENCY; j++) dl[j] = '0;
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_sat   = '0;
  endfunction

  // Drive one cycle (din as the block), advance the model, land at posedge+1.
  task automatic tick(input logic v);
    beat_t nb;
    coef_t c;
    int    acc;
    int    n;
    nb = '0;
    nb.v = v;
    for (int i = 0; i < NSAMPS; i++) data_i[i*NBITS +: NBITS] = din[i][NBITS-1:0];
    valid_i = v;
    if (v) begin
      for (int i = 0; i < NSAMPS; i++) xs.push_back(din[i]);
      for (int i = 0; i < NSAMPS; i++) begin
        n = xs.size() - NSAMPS + i;
        acc = 0;
        for (int k = 0; k < NTAPS; k++)
          if (n - k >= 0) acc += act_m[k] * xs[n - k];
        acc = acc >>> SHIFT;
        if (acc > OMAX) begin acc = OMAX; nb.s[i] = 1'b1; end
        else if (acc < OMIN) begin acc = OMIN; nb.s[i] = 1'b1; end
        nb.d[i*OUTBITS +: OUTBITS] = acc[OUTBITS-1:0];
      end
    end
    @(posedge aclk);
    #1;
    for (int j = LATENCY - 1; j > 0; j--) dl[j] = dl[j-1];
    dl[0] = nb;
    if (coef_wr && int'(coef_addr) < NTAPS) begin
      c = coef_dat;
      sh_m[coef_addr] = int'(c);
    end
    if (coef_commit) act_m = sh_m;
    exp_valid = dl[LATENCY-1].v;
    if (exp_valid) begin
      exp_data = dl[LATENCY-1].d;
      exp_sat  = dl[LATENCY-1].s;
    end
    coef_wr = 1'b0;
    coef_commit = 1'b0;
    valid_i = 1'b0;
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    valid_i = 1'b0;
    coef_wr = 1'b0;
    coef_commit = 1'b0;
    #2;
    model_reset();
    for (int i = 0; i < NSAMPS; i++) din[i] = 0;
    tick(1'b0);
    rst = 1'b0;
  endtask

  task automatic load_bank(input int h [NTAPS]);
    for (int k = 0; k < NTAPS; k++) begin
      coef_wr = 1'b1;
      coef_addr = AW'(k);
      coef_dat = CBITS'(h[k]);
      tick(1'b0);
    end
    coef_commit = 1'b1;
    tick(1'b0);
  endtask

  task automatic test_reset();
    int lat;
    lat = 0;
    rst = 1'b1;
    #2;
    nchk++; if (data_o !== '0) begin nerr++; $display("FAIL reset_data: got %h want 0", data_o); end
    nchk++; if (valid_o !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    nchk++; if (sat_o !== '0) begin nerr++; $display("FAIL reset_sat: got %h want 0", sat_o); end
    model_reset();
    tick(1'b0);
    rst = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      for (int i = 0; i < NSAMPS; i++) din[i] = int'($urandom_range(0, 4095)) - 2048;
      tick(1'b1);
      nchk++; if (valid_o !== exp_valid) begin nerr++; $display("FAIL zero_bank_valid c=%0d: got %b want %b", c, valid_o, exp_valid); end
      nchk++; if (data_o !== '0) begin nerr++; $display("FAIL zero_bank_data c=%0d: got %h want 0", c, data_o); end
      nchk++; if (sat_o !== '0) begin nerr++; $display("FAIL zero_bank_sat c=%0d: got %h want 0", c, sat_o); end
      if (lat == 0 && valid_o === 1'b1) lat = c;
    end
    nchk++; if (lat != LATENCY) begin nerr++; $display("FAIL first_valid_latency: got %0d want %0d", lat, LATENCY); end
  endtask

  task automatic test_impulse();
    logic [OUTBITS*NSAMPS-1:0] want;
    want = '0;
    want[3*OUTBITS +: OUTBITS] = 16'd100;
    hard_reset();
    coef_wr = 1'b1; coef_addr = '0; coef_dat = 4'd1;
    tick(1'b0);
    coef_commit = 1'b1;
    tick(1'b0);
    for (int c = 1; c <= LATENCY + 4; c++) begin
      for (int i = 0; i < NSAMPS; i++) din[i] = 0;
      if (c == 1) din[3] = 100;
      tick(1'b1);
      nchk++; if (valid_o !== exp_valid) begin nerr++; $display("FAIL impulse_valid c=%0d: got %b want %b", c, valid_o, exp_valid); end
      nchk++; if (data_o !== exp_data) begin nerr++; $display("FAIL impulse_data c=%0d: got %h want %h", c, data_o, exp_data); end
      if (c == LATENCY) begin
        nchk++; if (data_o !== want || valid_o !== 1'b1) begin nerr++; $display("FAIL impulse_lane3: got %h want %h", data_o, want); end
      end
    end
  endtask

  task automatic test_boundary();
    logic [OUTBITS*NSAMPS-1:0] want;
    want = '0;
    want[0 +: OUTBITS] = 16'hFFFB;
    hard_reset();
    coef_wr = 1'b1; coef_addr = AW'(9); coef_dat = 4'd1;
    tick(1'b0);
    coef_commit = 1'b1;
    tick(1'b0);
    for (int c = 1; c <= LATENCY + 4; c++) begin
      for (int i = 0; i < NSAMPS; i++) din[i] = 0;
      if (c == 1) din[7] = -5;
      tick(1'b1);
      nchk++; if (valid_o !== exp_valid) begin nerr++; $display("FAIL boundary_valid c=%0d: got %b want %b", c, valid_o, exp_valid); end
      nchk++; if (data_o !== exp_data) begin nerr++; $display("FAIL boundary_data c=%0d: got %h want %h", c, data_o, exp_data); end
      if (c == LATENCY + 2) begin
        nchk++; if (data_o !== want) begin nerr++; $display("FAIL boundary_block_n2: got %h want %h", data_o, want); end
      end
    end
  endtask

  task automatic test_golden();
    hard_reset();
    load_bank(h_golden);
    for (int c = 1; c <= 10000 + LATENCY; c++) begin
      for (int i = 0; i < NSAMPS; i++) din[i] = int'($urandom_range(0, 4095)) - 2048;
      tick(c <= 10000);
      nchk++; if (valid_o !== exp_valid) begin nerr++; $display("FAIL golden_valid c=%0d: got %b want %b", c, valid_o, exp_valid); end
      nchk++; if (data_o !== exp_data) begin nerr++; $display("FAIL golden_data c=%0d: got %h want %h", c, data_o, exp_data); end
      nchk++; if (sat_o !== exp_sat) begin nerr++; $display("FAIL golden_sat c=%0d: got %h want %h", c, sat_o, exp_sat); end
    end
  endtask

  task automatic test_saturation();
    int h [NTAPS];
    for (int k = 0; k < NTAPS; k++) h[k] = (k < 8) ? 7 : 0;
    hard_reset();
    load_bank(h);
    for (int c = 1; c <= LATENCY + 8; c++) begin
      for (int i = 0; i < NSAMPS; i++) din[i] = (c <= 4) ? 2047 : -2048;
      tick(c <= 8);
      nchk++; if (data_o !== exp_data) begin nerr++; $display("FAIL sat_data c=%0d: got %h want %h", c, data_o, exp_data); end
      nchk++; if (sat_o !== exp_sat) begin nerr++; $display("FAIL sat_flags c=%0d: got %h want %h", c, sat_o, exp_sat); end
      if (c == LATENCY + 3) begin
        nchk++; if (data_o !== {NSAMPS{16'h7FFF}} || sat_o !== 8'hFF) begin nerr++; $display("FAIL sat_high: got %h/%h want all 7fff/ff", data_o, sat_o); end
      end
      if (c == LATENCY + 7) begin
        nchk++; if (data_o !== {NSAMPS{16'h8000}} || sat_o !== 8'hFF) begin nerr++; $display("FAIL sat_low: got %h/%h want all 8000/ff", data_o, sat_o); end
      end
    end
  endtask

  task automatic test_commit_gaps();
    int   h [NTAPS];
    int   gap;
    logic v;
    for (int k = 0; k < NTAPS; k++) h[k] = int'($urandom_range(0, 15)) - 8;
    hard_reset();
    load_bank(h);
    gap = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NSAMPS; i++) din[i] = int'($urandom_range(0, 4095)) - 2048;
      if (c == 700) begin
        #3;
        rst = 1'b1;
        #1;
        nchk++; if (data_o !== '0) begin nerr++; $display("FAIL rst_mid_data: got %h want 0", data_o); end
        nchk++; if (valid_o !== 1'b0) begin nerr++; $display("FAIL rst_mid_valid: got %b want 0", valid_o); end
        nchk++; if (sat_o !== '0) begin nerr++; $display("FAIL rst_mid_sat: got %h want 0", sat_o); end
        model_reset();
        tick(1'b0);
        rst = 1'b0;
        continue;
      end
      if (gap > 0) begin
        v = 1'b0;
        gap--;
      end else begin
        v = 1'b1;
        gap = $urandom_range(0, 3);
      end
      if (c >= 300 && c < 400) begin
        coef_wr = 1'($urandom_range(0, 1));
        coef_addr = AW'($urandom_range(0, 63));
        coef_dat = CBITS'($urandom_range(0, 15));
      end
      if (c == 450 || c == 1100) begin
        coef_wr = 1'b1;
        coef_addr = AW'($urandom_range(0, NTAPS - 1));
        coef_dat = CBITS'($urandom_range(0, 15));
        coef_commit = 1'b1;
      end
      if (c >= 720 && c < 770) begin
        coef_wr = 1'b1;
        coef_addr = AW'(c - 720);
        coef_dat = CBITS'($urandom_range(0, 15));
      end
      if (c == 780) coef_commit = 1'b1;
      tick(v && c < 1500 - LATENCY - 4);
      nchk++; if (valid_o !== exp_valid) begin nerr++; $display("FAIL gaps_valid c=%0d: got %b want %b", c, valid_o, exp_valid); end
      nchk++; if (data_o !== exp_data) begin nerr++; $display("FAIL gaps_data c=%0d: got %h want %h", c, data_o, exp_data); end
      nchk++; if (sat_o !== exp_sat) begin nerr++; $display("FAIL gaps_sat c=%0d: got %h want %h", c, sat_o, exp_sat); end
    end
  endtask

  initial begin
    rst = 1'b1;
    data_i = '0;
    valid_i = 1'b0;
    coef_wr = 1'b0;
    coef_addr = '0;
    coef_dat = '0;
    coef_commit = 1'b0;
    for (int i = 0; i < NSAMPS; i++) din[i] = 0;
    model_reset();
    test_reset();
    test_impulse();
    test_boundary();
    test_saturation();
    test_commit_gaps();
    test_golden();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
